// File: rtl/peripheral_uart_rx.sv
// UART receiver for the J1 IO bus: 16x oversampled 8N1 framing into a small
// byte FIFO that the CPU drains through the peripheral register interface.
// Optional build macro UART_RX_PARITY_EN switches the frame to 8E1.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | line idle, waiting for a synchronized 1->0 edge
// S_START  | timing to mid start bit, rejects glitches
// S_DATA   | shifting in 8 data bits, LSB first, one per 16 ticks
// S_PARITY | (UART_RX_PARITY_EN only) sampling the even-parity bit
// S_STOP   | sampling the stop bit, pushes the byte or flags ferr
`timescale 1ns/1ps
module peripheral_uart_rx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int FIFO_AW  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out,
    input  logic        uart_rx,
    output logic        rx_ready
);
    localparam int DIV   = CLK_FREQ / (BAUD * 16);
    localparam int PS_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3
`ifdef UART_RX_PARITY_EN
        , S_PARITY = 3'd4
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [PS_W-1:0]    ps_q, ps_d;
    logic               sync1_q, sync2_q, prev_q;
    logic [3:0]         cnt_q, cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      fcnt_q, fcnt_d;
    logic               ovr_q, ovr_d, ferr_q, ferr_d, rx_ready_q, rx_ready_d;
    logic [7:0]         mem_q [DEPTH];
    logic               tick, rx_s, rx_fall, smp, push, ferr_set, perr_bit;
    logic               empty, full, pop, flush, clr, wr_en, ovr_set;
    logic               unused_din;
`ifdef UART_RX_PARITY_EN
    logic               perr_q, perr_d, par_bad_q, par_bad_d, perr_set;
`endif

    assign tick     = (ps_q == PS_W'(DIV - 1));
    assign ps_d     = tick ? '0 : ps_q + 1'b1;
    assign rx_s     = sync2_q;
    assign rx_fall  = prev_q & ~sync2_q;
    assign smp      = tick && (cnt_q == 4'd0);
    assign rx_ready = rx_ready_q;
    assign unused_din = ^d_in[15:2];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; every bit decision is taken on the sample strobe
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (rx_fall) state_d = S_START;
            S_START:  if (smp) state_d = rx_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
            S_DATA:   if (smp && bit_idx_q == 3'd7) state_d = S_PARITY;
            S_PARITY: if (smp) state_d = S_STOP;
`else
            S_DATA:   if (smp && bit_idx_q == 3'd7) state_d = S_STOP;
`endif
            S_STOP:   if (smp) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic: sample down-counter, shifter, push and error strobes
    always_comb begin
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_set  = 1'b0;
`endif
        if (state_q == S_IDLE) begin
            if (rx_fall) cnt_d = 4'd7;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
        end else if (tick) begin
            cnt_d = smp ? 4'd15 : cnt_q - 4'd1;
        end
        case (state_q)
            S_START: if (smp) bit_idx_d = 3'd0;
            S_DATA: if (smp) begin
                shift_d   = {rx_s, shift_q[7:1]};
                bit_idx_d = bit_idx_q + 3'd1;
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (smp && ((^shift_q) ^ rx_s)) begin
                perr_set  = 1'b1;
                par_bad_d = 1'b1;
            end
            S_STOP: if (smp) begin
                push     = rx_s & ~par_bad_q;
                ferr_set = ~rx_s;
            end
`else
            S_STOP: if (smp) begin
                push     = rx_s;
                ferr_set = ~rx_s;
            end
`endif
            default: ;
        endcase
    end

    // FIFO bookkeeping, register-side pop/flush/clear and sticky error flags
    always_comb begin
        empty   = (fcnt_q == '0);
        full    = (fcnt_q == CW'(DEPTH));
        pop     = cs && rd && (addr == 4'h0) && !empty;
        flush   = cs && wr && (addr == 4'h4) && d_in[1];
        clr     = cs && wr && (addr == 4'h4) && d_in[0];
        wr_en   = push && !flush && (!full || pop);
        ovr_set = push && !flush && full && !pop;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            fcnt_d   = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(pop);
            wr_ptr_d = wr_ptr_q + FIFO_AW'(wr_en);
            fcnt_d   = fcnt_q + CW'(wr_en) - CW'(pop);
        end
        rx_ready_d = (fcnt_d != '0);
        ovr_d  = ovr_set  ? 1'b1 : (clr ? 1'b0 : ovr_q);
        ferr_d = ferr_set ? 1'b1 : (clr ? 1'b0 : ferr_q);
`ifdef UART_RX_PARITY_EN
        perr_d   = perr_set ? 1'b1 : (clr ? 1'b0 : perr_q);
        perr_bit = perr_q;
`else
        perr_bit = 1'b0;
`endif
    end

    // Datapath and FIFO control registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_q       <= '0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fcnt_q     <= '0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            rx_ready_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q     <= 1'b0;
            par_bad_q  <= 1'b0;
`endif
        end else begin
            ps_q       <= ps_d;
            sync1_q    <= uart_rx;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fcnt_q     <= fcnt_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
            rx_ready_q <= rx_ready_d;
`ifdef UART_RX_PARITY_EN
            perr_q     <= perr_d;
            par_bad_q  <= par_bad_d;
`endif
        end
    end

    // FIFO storage; on a full pop+push the slot being read is rewritten at the same edge
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= shift_q;
    end

    // Combinational read mux
    always_comb begin
        d_out = 16'h0000;
        if (cs) begin
            case (addr)
                4'h0:    d_out = empty ? 16'h0000 : {8'h00, mem_q[rd_ptr_q]};
                4'h2:    d_out = {11'b0, perr_bit, ferr_q, ovr_q, full, !empty};
                default: d_out = 16'h0000;
            endcase
        end
    end
endmodule

// File: tb/tb_peripheral_uart_rx.sv
// Scoreboard bench for peripheral_uart_rx at DIV=1 (one bit = 16 clk).
`timescale 1ns/1ps
module tb_peripheral_uart_rx;
    localparam int DEPTH = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] d_in = '0;
    logic        cs = 1'b0;
    logic [3:0]  addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] d_out;
    logic        uart_rx = 1'b1;
    logic        rx_ready;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];
    bit exp_ovr = 0, exp_ferr = 0, exp_perr = 0;
    logic [15:0] v;

    peripheral_uart_rx #(.CLK_FREQ(1600000), .BAUD(100000), .FIFO_AW(3)) dut (
        .clk(clk), .rst(rst), .d_in(d_in), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
        .d_out(d_out), .uart_rx(uart_rx), .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_status();
        return {11'b0, exp_perr, exp_ferr, exp_ovr, exp_q.size() == DEPTH, exp_q.size() != 0};
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input logic cs_v, input logic [3:0] a, output logic [15:0] d);
        cs = cs_v; addr = a; rd = 1'b1;
        @(negedge clk);
        d = d_out;
        @(posedge clk);
        #1;
        cs = 1'b0; rd = 1'b0; addr = '0;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
        cs = 1'b1; addr = a; wr = 1'b1; d_in = d;
        @(posedge clk);
        #1;
        cs = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
    endtask

    task automatic check_status(input string tag);
        read_reg(1'b1, 4'h2, v);
        check_eq(tag, v, exp_status());
    endtask

    task automatic drain(input string tag);
        logic [7:0] e;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            read_reg(1'b1, 4'h0, v);
            check_eq(tag, v, {8'h00, e});
        end
    endtask

    // Frame timing: stop bit sampled 11 posedges after the stop bit is driven.
    task automatic send_frame(input logic [7:0] data, input bit stop_bit, input bit par_flip,
                              input bit pop_at_push, input bit chk_ready);
        bit good;
        uart_rx = 1'b0;
        cycles(16);
        for (int i = 0; i < 8; i++) begin
            uart_rx = data[i];
            cycles(16);
        end
        if (PAR) begin
            uart_rx = (^data) ^ par_flip;
            cycles(16);
        end
        uart_rx = stop_bit;
        cycles(10);
        if (pop_at_push) begin
            cs = 1'b1; addr = 4'h0; rd = 1'b1;
        end
        @(negedge clk);
        if (chk_ready) check_eq("rx_ready_before_stop", {15'b0, rx_ready}, 16'h0000);
        if (pop_at_push) check_eq("pop_push_head", d_out, {8'h00, exp_q[0]});
        @(posedge clk);
        #1;
        cs = 1'b0; rd = 1'b0;
        @(negedge clk);
        if (chk_ready) check_eq("rx_ready_after_stop", {15'b0, rx_ready}, 16'h0001);
        cycles(5);
        uart_rx = 1'b1;
        cycles(4);
        if (pop_at_push) void'(exp_q.pop_front());
        good = stop_bit && !(PAR && par_flip);
        if (!stop_bit) exp_ferr = 1;
        if (PAR && par_flip) exp_perr = 1;
        if (good) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(data);
            else exp_ovr = 1;
        end
    endtask

    initial begin
        // reset and mid-frame reset
        cycles(3);
        rst = 1'b1;
        cycles(2);
        uart_rx = 1'b0;
        cycles(40);
        #2 rst = 1'b0;
        cycles(3);
        uart_rx = 1'b1;
        cycles(2);
        rst = 1'b1;
        cycles(2);
        read_reg(1'b1, 4'h0, v);
        check_eq("reset_data", v, 16'h0000);
        read_reg(1'b1, 4'h2, v);
        check_eq("reset_status", v, 16'h0000);
        check_eq("reset_rx_ready", {15'b0, rx_ready}, 16'h0000);
        cycles(200);
        check_status("post_reset_idle");

        // single byte
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
        check_status("a5_status");
        read_reg(1'b0, 4'h0, v);
        check_eq("cs_low_read", v, 16'h0000);
        read_reg(1'b1, 4'h1, v);
        check_eq("other_addr_read", v, 16'h0000);
        drain("a5_data");
        check_status("a5_after_read");
        read_reg(1'b1, 4'h0, v);
        check_eq("empty_read", v, 16'h0000);
        check_status("empty_read_status");

        // glitch on idle line
        uart_rx = 1'b0;
        cycles(5);
        uart_rx = 1'b1;
        cycles(40);
        check_status("glitch_status");
        check_eq("glitch_rx_ready", {15'b0, rx_ready}, 16'h0000);

        // overrun
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        check_status("ovr_status");
        drain("ovr_data");
        check_status("ovr_drained_status");
        write_reg(4'h4, 16'h0001);
        exp_ovr = 0;
        check_status("ovr_cleared");

        // framing error then good byte
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        check_status("ferr_status");
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        check_status("after_ferr_status");
        drain("after_ferr_data");
        write_reg(4'h4, 16'h0001);
        exp_ferr = 0;
        check_status("ferr_cleared");

        // simultaneous pop and push on a full FIFO
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        check_status("full_status");
        send_frame(8'h18, 1'b1, 1'b0, 1'b1, 1'b0);
        check_status("pop_push_status");
        drain("pop_push_data");
        check_status("pop_push_drained");

        // flush
        send_frame(8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h88, 1'b1, 1'b0, 1'b0, 1'b0);
        check_status("pre_flush_status");
        write_reg(4'h4, 16'h0002);
        exp_q.delete();
        check_status("flush_status");
        check_eq("flush_rx_ready", {15'b0, rx_ready}, 16'h0000);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1);
        drain("post_flush_data");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
        check_status("perr_status");
        write_reg(4'h4, 16'h0001);
        exp_perr = 0;
        check_status("perr_cleared");
        send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
        check_status("parity_good_status");
        drain("parity_good_data");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
